// File: rtl/spi_flash_rd_pkg.sv
// spi_flash_rd_pkg
//   Register map, control-word layout and flash opcode shared by the flash
//   reader and the SPI master. It also holds the reader FSM state type.
//   Ports: none (package).
package spi_flash_rd_pkg;

    // SPI master register offsets
    localparam logic [31:0] SPI_REG_CTRL = 32'h0000_0000;
    localparam logic [31:0] SPI_REG_DATA = 32'h0000_0004;
    localparam logic [31:0] SPI_REG_STAT = 32'h0000_0008;

    // Bit positions in the control and status registers
    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_CPOL_BIT = 1;
    localparam int unsigned CTRL_CPHA_BIT = 2;
    localparam int unsigned CTRL_SS_BIT   = 3;
    localparam int unsigned CTRL_DIV_LSB  = 8;
    localparam int unsigned STAT_BUSY_BIT = 0;

    // Serial flash READ opcode
    localparam logic [7:0] FLASH_CMD_READ = 8'h03;

    typedef enum logic [3:0] {
        IDLE,
        SEL,
        LOAD,
        KICK,
        WAIT_BUSY,
        WAIT_IDLE,
        CAPTURE,
        DESEL,
        DONE
    } state_t;

    // Builds the control-register value {div, 4'b0, ss, cpha, cpol, en}
    function automatic logic [31:0] ctrl_word(
        input logic [7:0] div,
        input logic       ss,
        input logic       cpha,
        input logic       cpol,
        input logic       en
    );
        logic [31:0] w;
        w                      = '0;
        w[CTRL_DIV_LSB +: 8]   = div;
        w[CTRL_SS_BIT]         = ss;
        w[CTRL_CPHA_BIT]       = cpha;
        w[CTRL_CPOL_BIT]       = cpol;
        w[CTRL_EN_BIT]         = en;
        return w;
    endfunction

endpackage

// File: rtl/spi_flash_rd_if.sv
// spi_flash_rd_if
//   Bus bundle between the flash reader and its two slaves: the SPI master
//   register port and the destination memory write port.
//   Signals:
//     spi_addr_o / spi_data_o / spi_we_o : register access to the SPI master
//     spi_data_i                         : combinational read data at spi_addr_o
//     mem_addr_o / mem_data_o / mem_we_o : destination memory word write
//   Modports: master (flash reader), slave (SPI master + memory side).
interface spi_flash_rd_if;

    logic [31:0] spi_addr_o;
    logic [31:0] spi_data_o;
    logic        spi_we_o;
    logic [31:0] spi_data_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_we_o;

    modport master (
        output spi_addr_o,
        output spi_data_o,
        output spi_we_o,
        input  spi_data_i,
        output mem_addr_o,
        output mem_data_o,
        output mem_we_o
    );

    modport slave (
        input  spi_addr_o,
        input  spi_data_o,
        input  spi_we_o,
        output spi_data_i,
        input  mem_addr_o,
        input  mem_data_o,
        input  mem_we_o
    );

endinterface

// File: rtl/spi_flash_rd.sv
// spi_flash_rd
//   Reads byte_num_i bytes from a serial flash starting at flash_addr_i by
//   driving a register-mapped SPI master, and writes them little-endian
//   packed into 32-bit words at mem_base_i, mem_base_i+4, ...
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     start_i         : one-cycle request, accepted only in IDLE
//     flash_addr_i    : flash byte address (sampled on accepted start)
//     byte_num_i      : byte count (sampled on accepted start)
//     mem_base_i      : destination word address base (sampled on accepted start)
//     bus             : SPI register port and memory write port (master side)
//     busy_o, done_o  : status level and one-cycle completion pulse
module spi_flash_rd
    import spi_flash_rd_pkg::*;
#(
    parameter logic [7:0] CLK_DIV = 8'd1,
    parameter logic       CPOL    = 1'b0,
    parameter logic       CPHA    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [23:0]          flash_addr_i,
    input  logic [15:0]          byte_num_i,
    input  logic [31:0]          mem_base_i,
    spi_flash_rd_if.master       bus,
    output logic                 busy_o,
    output logic                 done_o
);

    state_t      state_q, state_d;

    logic [23:0] flash_addr_q;
    logic [15:0] byte_num_q;
    logic [31:0] wr_addr_q;
    logic [16:0] byte_idx_q;   // bytes exchanged so far, header included
    logic [31:0] word_q;       // partially assembled data word
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_data_q;

    logic [31:0] spi_addr;
    logic [31:0] spi_data;
    logic        spi_we;
    logic [7:0]  tx_byte;
    logic [7:0]  rx_byte;
    logic        stat_busy;
    logic        is_data;
    logic        last_byte;
    logic        word_flush;
    logic [31:0] word_next;
    logic        unused_rd_bits;

    assign rx_byte        = bus.spi_data_i[7:0];
    assign stat_busy      = bus.spi_data_i[STAT_BUSY_BIT];
    assign unused_rd_bits = &{1'b0, bus.spi_data_i[31:8]};

    assign is_data    = (byte_idx_q >= 17'd4);
    assign last_byte  = (byte_idx_q == ({1'b0, byte_num_q} + 17'd3));
    // Data byte k sits at byte_idx k+4, so its lane k%4 equals byte_idx%4.
    assign word_flush = is_data && ((byte_idx_q[1:0] == 2'b11) || last_byte);

    always_comb begin
        word_next = word_q;
        word_next[{byte_idx_q[1:0], 3'b000} +: 8] = rx_byte;
    end

    always_comb begin
        tx_byte = '0;
        case (byte_idx_q)
            17'd0:   tx_byte = FLASH_CMD_READ;
            17'd1:   tx_byte = flash_addr_q[23:16];
            17'd2:   tx_byte = flash_addr_q[15:8];
            17'd3:   tx_byte = flash_addr_q[7:0];
            default: tx_byte = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        spi_addr = '0;
        spi_data = '0;
        spi_we   = 1'b0;
        done_o   = 1'b0;
        busy_o   = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (byte_num_i == 16'd0) ? DONE : SEL;
                end
            end
            SEL: begin
                spi_addr = SPI_REG_CTRL;
                spi_data = ctrl_word(CLK_DIV, 1'b1, CPHA, CPOL, 1'b0);
                spi_we   = 1'b1;
                state_d  = LOAD;
            end
            LOAD: begin
                spi_addr = SPI_REG_DATA;
                spi_data = {24'h0, tx_byte};
                spi_we   = 1'b1;
                state_d  = KICK;
            end
            KICK: begin
                spi_addr = SPI_REG_CTRL;
                spi_data = ctrl_word(CLK_DIV, 1'b1, CPHA, CPOL, 1'b1);
                spi_we   = 1'b1;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                spi_addr = SPI_REG_STAT;
                if (stat_busy) begin
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                spi_addr = SPI_REG_STAT;
                if (!stat_busy) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                spi_addr = SPI_REG_DATA;
                state_d  = last_byte ? DESEL : LOAD;
            end
            DESEL: begin
                spi_addr = SPI_REG_CTRL;
                spi_data = ctrl_word(CLK_DIV, 1'b0, CPHA, CPOL, 1'b0);
                spi_we   = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Transfer context, byte counter and word assembly. The memory write is
    // registered, so it appears the cycle after the CAPTURE that completed it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_addr_q <= '0;
            byte_num_q   <= '0;
            wr_addr_q    <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        flash_addr_q <= flash_addr_i;
                        byte_num_q   <= byte_num_i;
                        wr_addr_q    <= mem_base_i;
                        byte_idx_q   <= '0;
                        word_q       <= '0;
                    end
                end
                CAPTURE: begin
                    if (word_flush) begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= wr_addr_q;
                        mem_data_q <= word_next;
                        wr_addr_q  <= wr_addr_q + 32'd4;
                        word_q     <= '0;
                    end else if (is_data) begin
                        word_q <= word_next;
                    end
                    byte_idx_q <= byte_idx_q + 17'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.spi_addr_o = spi_addr;
    assign bus.spi_data_o = spi_data;
    assign bus.spi_we_o   = spi_we;
    assign bus.mem_we_o   = mem_we_q;
    assign bus.mem_addr_o = mem_addr_q;
    assign bus.mem_data_o = mem_data_q;

endmodule

// File: tb/tb_spi_flash_rd.sv
// tb_spi_flash_rd
//   Scoreboard bench for spi_flash_rd: a behavioural SPI master answers
//   register accesses; expected SPI and memory writes are queued when a read
//   is issued and a negedge monitor pops and compares them as they occur.
module tb_spi_flash_rd;

    localparam logic [7:0] P_DIV  = 8'h04;
    localparam logic       P_CPOL = 1'b1;
    localparam logic       P_CPHA = 1'b0;

    // {div, 4'b0, ss, cpha, cpol, en} with div=0x04, cpol=1, cpha=0
    localparam logic [31:0] C_SEL   = 32'h0000_040A;
    localparam logic [31:0] C_KICK  = 32'h0000_040B;
    localparam logic [31:0] C_DESEL = 32'h0000_0402;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [23:0] flash_addr_i;
    logic [15:0] byte_num_i;
    logic [31:0] mem_base_i;
    logic        busy_o;
    logic        done_o;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned loads_seen = 0;
    int unsigned done_seen  = 0;
    int unsigned spi_wr_cnt = 0;
    int unsigned mem_wr_cnt = 0;

    wr_t        spi_exp[$];
    wr_t        mem_exp[$];
    logic [7:0] rx_src[$];

    spi_flash_rd_if bus_if ();

    spi_flash_rd #(
        .CLK_DIV (P_DIV),
        .CPOL    (P_CPOL),
        .CPHA    (P_CPHA)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .flash_addr_i (flash_addr_i),
        .byte_num_i   (byte_num_i),
        .mem_base_i   (mem_base_i),
        .bus          (bus_if.master),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SPI master: a kick makes status busy for three cycles,
    // after which the rx register holds the next byte from rx_src.
    logic [31:0] m_ctrl;
    logic [7:0]  m_rx;
    logic [7:0]  m_pend;
    logic        m_busy;
    int unsigned m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ctrl <= '0;
            m_rx   <= '0;
            m_pend <= '0;
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else begin
            if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy <= 1'b0;
                    m_rx   <= m_pend;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (bus_if.spi_we_o && bus_if.spi_addr_o == 32'h0) begin
                m_ctrl <= bus_if.spi_data_o;
                if (bus_if.spi_data_o[0]) begin
                    m_busy <= 1'b1;
                    m_cnt  <= 2;
                    if (rx_src.size() > 0) m_pend <= rx_src.pop_front();
                    else                   m_pend <= 8'hEE;
                end
            end
        end
    end

    assign bus_if.spi_data_i = (bus_if.spi_addr_o == 32'h0) ? m_ctrl :
                               (bus_if.spi_addr_o == 32'h4) ? {24'h0, m_rx} :
                               (bus_if.spi_addr_o == 32'h8) ? {31'h0, m_busy} : 32'h0;

    // Monitor: every SPI or memory write must match the head of its queue.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (bus_if.spi_we_o) begin
                spi_wr_cnt++;
                if (bus_if.spi_addr_o == 32'h4) loads_seen++;
                n_checks++;
                if (spi_exp.size() == 0) begin
                    n_fail++;
                    $display("FAIL spi_wr: got a=%h d=%h, expected no write",
                             bus_if.spi_addr_o, bus_if.spi_data_o);
                end else begin
                    e = spi_exp.pop_front();
                    if (bus_if.spi_addr_o !== e.a || bus_if.spi_data_o !== e.d) begin
                        n_fail++;
                        $display("FAIL spi_wr: got a=%h d=%h, expected a=%h d=%h",
                                 bus_if.spi_addr_o, bus_if.spi_data_o, e.a, e.d);
                    end
                end
            end
            if (bus_if.mem_we_o) begin
                mem_wr_cnt++;
                n_checks++;
                if (mem_exp.size() == 0) begin
                    n_fail++;
                    $display("FAIL mem_wr: got a=%h d=%h, expected no write",
                             bus_if.mem_addr_o, bus_if.mem_data_o);
                end else begin
                    e = mem_exp.pop_front();
                    if (bus_if.mem_addr_o !== e.a || bus_if.mem_data_o !== e.d) begin
                        n_fail++;
                        $display("FAIL mem_wr: got a=%h d=%h, expected a=%h d=%h",
                                 bus_if.mem_addr_o, bus_if.mem_data_o, e.a, e.d);
                    end
                end
            end
            if (done_o) done_seen++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},     {31'h0, busy_o},          32'h0);
        chk({tag, "_done"},     {31'h0, done_o},          32'h0);
        chk({tag, "_spi_we"},   {31'h0, bus_if.spi_we_o}, 32'h0);
        chk({tag, "_mem_we"},   {31'h0, bus_if.mem_we_o}, 32'h0);
        chk({tag, "_spi_addr"}, bus_if.spi_addr_o,        32'h0);
        chk({tag, "_spi_data"}, bus_if.spi_data_o,        32'h0);
        chk({tag, "_mem_addr"}, bus_if.mem_addr_o,        32'h0);
        chk({tag, "_mem_data"}, bus_if.mem_data_o,        32'h0);
    endtask

    function automatic wr_t mk(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        return w;
    endfunction

    // Expected SPI register traffic for one read of n bytes at flash address a
    task automatic exp_spi(input logic [23:0] a, input int unsigned n);
        logic [7:0] tx;
        spi_exp.push_back(mk(32'h0, C_SEL));
        for (int unsigned i = 0; i < n + 4; i++) begin
            case (i)
                0:       tx = 8'h03;
                1:       tx = a[23:16];
                2:       tx = a[15:8];
                3:       tx = a[7:0];
                default: tx = 8'h00;
            endcase
            spi_exp.push_back(mk(32'h4, {24'h0, tx}));
            spi_exp.push_back(mk(32'h0, C_KICK));
        end
        spi_exp.push_back(mk(32'h0, C_DESEL));
    endtask

    // Header replies are junk that must never reach memory
    task automatic feed_rx(input logic [7:0] first, input int unsigned n);
        for (int unsigned i = 0; i < 4; i++) rx_src.push_back(8'hC5);
        for (int unsigned i = 0; i < n; i++) rx_src.push_back(first + 8'(i));
    endtask

    task automatic start_read(input logic [23:0] a, input logic [15:0] n, input logic [31:0] base);
        @(negedge clk);
        flash_addr_i = a;
        byte_num_i   = n;
        mem_base_i   = base;
        start_i      = 1'b1;
        @(negedge clk);
        start_i      = 1'b0;
    endtask

    task automatic finish_read(input string tag, input int unsigned done_before);
        for (int unsigned c = 0; c < 3000; c++) begin
            @(posedge clk);
            if (done_seen != done_before) break;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_done_count"}, done_seen - done_before, 32'd1);
        chk({tag, "_spi_left"},   spi_exp.size(),          32'd0);
        chk({tag, "_mem_left"},   mem_exp.size(),          32'd0);
        chk({tag, "_busy_after"}, {31'h0, busy_o},         32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned d0;
        int unsigned s0;
        int unsigned m0;
        int unsigned l0;

        rst_n        = 1'b0;
        start_i      = 1'b0;
        flash_addr_i = '0;
        byte_num_i   = '0;
        mem_base_i   = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 4 bytes -> one full word
        d0 = done_seen;
        feed_rx(8'h11, 0);
        rx_src.push_back(8'h11); rx_src.push_back(8'h22);
        rx_src.push_back(8'h33); rx_src.push_back(8'h44);
        exp_spi(24'h001000, 4);
        mem_exp.push_back(mk(32'h0000_2000, 32'h4433_2211));
        start_read(24'h001000, 16'd4, 32'h0000_2000);
        chk("t1_busy_after_start", {31'h0, busy_o}, 32'h1);
        finish_read("t1", d0);

        // 6 bytes -> full word then zero-padded partial word
        d0 = done_seen;
        feed_rx(8'hA0, 6);
        exp_spi(24'h001000, 6);
        mem_exp.push_back(mk(32'h0000_2000, 32'hA3A2_A1A0));
        mem_exp.push_back(mk(32'h0000_2004, 32'h0000_A5A4));
        start_read(24'h001000, 16'd6, 32'h0000_2000);
        finish_read("t2", d0);

        // zero length: done the cycle after start, no bus activity
        d0 = done_seen;
        s0 = spi_wr_cnt;
        m0 = mem_wr_cnt;
        start_read(24'h001000, 16'd0, 32'h0000_2000);
        chk("t3_done_at_start_plus1", {31'h0, done_o}, 32'h1);
        repeat (4) @(negedge clk);
        chk("t3_done_count", done_seen - d0, 32'd1);
        chk("t3_spi_writes", spi_wr_cnt - s0, 32'd0);
        chk("t3_mem_writes", mem_wr_cnt - m0, 32'd0);

        // start re-asserted while busy must not disturb the transfer
        d0 = done_seen;
        feed_rx(8'h5A, 0);
        rx_src.push_back(8'h5A); rx_src.push_back(8'h6B);
        exp_spi(24'h001000, 2);
        mem_exp.push_back(mk(32'h0000_3000, 32'h0000_6B5A));
        start_read(24'h001000, 16'd2, 32'h0000_3000);
        repeat (10) @(negedge clk);
        chk("t4_busy_during", {31'h0, busy_o}, 32'h1);
        start_read(24'hABCDEF, 16'd9, 32'h0000_9000);
        finish_read("t4", d0);

        // reset during the second data byte abandons the transfer
        d0 = done_seen;
        l0 = loads_seen;
        feed_rx(8'h70, 4);
        exp_spi(24'h001000, 4);
        start_read(24'h001000, 16'd4, 32'h0000_2000);
        for (int unsigned c = 0; c < 3000; c++) begin
            @(posedge clk);
            if (loads_seen - l0 >= 6) break;
        end
        chk("t5_reached_byte5", {31'h0, 1'(loads_seen - l0 >= 6)}, 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("t5_rst");
        spi_exp.delete();
        rx_src.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_no_done_abort", done_seen - d0, 32'd0);
        chk("t5_idle_after_rst", {31'h0, busy_o}, 32'h0);
        d0 = done_seen;
        feed_rx(8'h01, 4);
        exp_spi(24'h000040, 4);
        mem_exp.push_back(mk(32'h0000_0100, 32'h0403_0201));
        start_read(24'h000040, 16'd4, 32'h0000_0100);
        finish_read("t5_clean", d0);

        // destination address wraps past 0xFFFFFFFF
        d0 = done_seen;
        feed_rx(8'h10, 8);
        exp_spi(24'h001000, 8);
        mem_exp.push_back(mk(32'hFFFF_FFFC, 32'h1312_1110));
        mem_exp.push_back(mk(32'h0000_0000, 32'h1716_1514));
        start_read(24'h001000, 16'd8, 32'hFFFF_FFFC);
        finish_read("t6", d0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
